// File: rtl/ecliptic_fp_simple_unit_if.sv
// Request/acknowledge bundle for the ecliptic FP simple unit.
interface ecliptic_fp_simple_unit_if;
  logic        req;
  logic [1:0]  func;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ack;
  logic [31:0] res;
  logic        invalid;

  modport master (
    output req, func, op, src1, src2,
    input  ack, res, invalid
  );

  modport slave (
    input  req, func, op, src1, src2,
    output ack, res, invalid
  );
endinterface

// File: rtl/ecliptic_fp_simple_unit.sv
// Binary32 sign-inject, classify and compare/min-max; one-cycle latency.
// FMIN/FMAX are built only when ECLIPTIC_MINMAX_EN is defined.
module ecliptic_fp_simple_unit (
  input logic clk,
  input logic nrst,
  ecliptic_fp_simple_unit_if.slave bus
);

  logic [31:0] a;
  logic [31:0] b;
  assign a = bus.src1;
  assign b = bus.src2;

  logic aExpMax;
  logic bExpMax;
  logic aExpZero;
  logic aFracZero;
  logic bFracZero;
  assign aExpMax   = &a[30:23];
  assign bExpMax   = &b[30:23];
  assign aExpZero  = ~|a[30:23];
  assign aFracZero = ~|a[22:0];
  assign bFracZero = ~|b[22:0];

  logic aNan;
  logic bNan;
  logic aSnan;
  logic bSnan;
  logic anyNan;
  logic anySnan;
  assign aNan    = aExpMax & ~aFracZero;
  assign bNan    = bExpMax & ~bFracZero;
  assign aSnan   = aNan & ~a[22];
  assign bSnan   = bNan & ~b[22];
  assign anyNan  = aNan | bNan;
  assign anySnan = aSnan | bSnan;

  // Sign injection
  logic [31:0] sgnRes;
  always_comb begin
    sgnRes = a;
    case (bus.op[1:0])
      2'b00:   sgnRes = {b[31], a[30:0]};
      2'b01:   sgnRes = {~b[31], a[30:0]};
      2'b10:   sgnRes = {a[31] ^ b[31], a[30:0]};
      default: sgnRes = a;
    endcase
  end

  // Classification
  logic [31:0] clsRes;
  always_comb begin
    clsRes = '0;
    unique case (1'b1)
      aNan & a[22]:          clsRes[9] = 1'b1;
      aNan & ~a[22]:         clsRes[8] = 1'b1;
      aExpMax & aFracZero:   clsRes[a[31] ? 0 : 7] = 1'b1;
      aExpZero & aFracZero:  clsRes[a[31] ? 3 : 4] = 1'b1;
      aExpZero & ~aFracZero: clsRes[a[31] ? 2 : 5] = 1'b1;
      default:               clsRes[a[31] ? 1 : 6] = 1'b1;
    endcase
  end

  logic magLt;
  logic magGt;
  logic bothZero;
  logic ordLt;
  logic fLt;
  logic fEq;
  logic fLe;
  assign magLt    = a[30:0] < b[30:0];
  assign magGt    = a[30:0] > b[30:0];
  assign bothZero = ~|(a[30:0] | b[30:0]);
  // Total order on sign-magnitude: -0 sits below +0
  assign ordLt = (a[31] != b[31]) ? a[31]
               : (a[31] ? magGt : magLt);
  assign fLt = ~anyNan & ~bothZero & ordLt;
  assign fEq = ~anyNan & ((a == b) | bothZero);
  assign fLe = fLt | fEq;

`ifdef ECLIPTIC_MINMAX_EN
  logic [31:0] minRes;
  logic [31:0] maxRes;
  always_comb begin
    minRes = ordLt ? a : b;
    maxRes = ordLt ? b : a;
    if (aNan & bNan) begin
      minRes = 32'h7FC0_0000;
      maxRes = 32'h7FC0_0000;
    end else if (aNan) begin
      minRes = b;
      maxRes = b;
    end else if (bNan) begin
      minRes = a;
      maxRes = a;
    end
  end
`endif

  logic [31:0] cmpRes;
  logic        cmpInv;
  always_comb begin
    cmpRes = '0;
    cmpInv = 1'b0;
    case (bus.op)
      3'b000: begin
        cmpRes = {31'b0, fLe};
        cmpInv = anyNan;
      end
      3'b001: begin
        cmpRes = {31'b0, fLt};
        cmpInv = anyNan;
      end
      3'b010: begin
        cmpRes = {31'b0, fEq};
        cmpInv = anySnan;
      end
`ifdef ECLIPTIC_MINMAX_EN
      3'b100: begin
        cmpRes = minRes;
        cmpInv = anySnan;
      end
      3'b101: begin
        cmpRes = maxRes;
        cmpInv = anySnan;
      end
`endif
      default: begin
        cmpRes = '0;
        cmpInv = 1'b0;
      end
    endcase
  end

  logic [31:0] nextRes;
  logic        nextInv;
  always_comb begin
    nextRes = '0;
    nextInv = 1'b0;
    case (bus.func)
      2'b00: nextRes = sgnRes;
      2'b01: nextRes = clsRes;
      2'b10: begin
        nextRes = cmpRes;
        nextInv = cmpInv;
      end
      default: begin
        nextRes = '0;
        nextInv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.ack     <= 1'b0;
      bus.res     <= '0;
      bus.invalid <= 1'b0;
    end else begin
      bus.ack <= bus.req;
      if (bus.req) begin
        bus.res     <= nextRes;
        bus.invalid <= nextInv;
      end
    end
  end

endmodule

// File: tb/tb_ecliptic_fp_simple_unit.sv
// Scoreboard bench for ecliptic_fp_simple_unit.
module tb_ecliptic_fp_simple_unit;

  logic clk;
  logic nrst;
  int   compared;
  int   mismatched;
  logic [32:0] expQ[$];
  logic [31:0] lastRes;

  ecliptic_fp_simple_unit_if bus ();

  ecliptic_fp_simple_unit dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst && bus.ack) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_ack got res=%h inv=%b", bus.res, bus.invalid);
      end else begin
        logic [32:0] e;
        e = expQ.pop_front();
        if (bus.res !== e[31:0] || bus.invalid !== e[32]) begin
          mismatched++;
          $display("FAIL result got res=%h inv=%b want res=%h inv=%b",
                   bus.res, bus.invalid, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [2:0] o,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] er, input logic ei);
    bus.req  = 1'b1;
    bus.func = f;
    bus.op   = o;
    bus.src1 = s1;
    bus.src2 = s2;
    expQ.push_back({ei, er});
    lastRes = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkZero(input string name);
    compared++;
    if (bus.ack !== 1'b0 || bus.res !== 32'h0 || bus.invalid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s got ack=%b res=%h inv=%b want 0/0/0",
               name, bus.ack, bus.res, bus.invalid);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    bus.req = 1'b0;
    while (expQ.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout got pending=%0d want 0", expQ.size());
      expQ.delete();
    end
  endtask

  localparam logic [1:0] SGN = 2'b00;
  localparam logic [1:0] CLS = 2'b01;
  localparam logic [1:0] CMP = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  initial begin
    compared   = 0;
    mismatched = 0;
    lastRes    = '0;
    nrst     = 1'b0;
    bus.req  = 1'b0;
    bus.func = '0;
    bus.op   = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    #3;
    checkZero("reset_state");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    idle(1);

    issue(SGN, 3'b000, 32'h3F800000, 32'hCF800000, 32'hBF800000, 1'b0);
    issue(SGN, 3'b001, 32'h3F800000, 32'hCF800000, 32'h3F800000, 1'b0);
    issue(SGN, 3'b010, 32'hBF800000, 32'hCF800000, 32'h3F800000, 1'b0);
    issue(SGN, 3'b011, 32'hBF800000, 32'h00000000, 32'hBF800000, 1'b0);
    issue(SGN, 3'b100, 32'h7FC00001, 32'h00000000, 32'h7FC00001, 1'b0);
    idle(1);

    issue(CLS, 3'b000, 32'h3F800000, 32'h0, 32'h00000040, 1'b0);
    issue(CLS, 3'b000, 32'h7F800001, 32'h0, 32'h00000100, 1'b0);
    issue(CLS, 3'b000, 32'h00000003, 32'h0, 32'h00000020, 1'b0);
    issue(CLS, 3'b000, 32'hFF800000, 32'h0, 32'h00000001, 1'b0);
    issue(CLS, 3'b000, 32'h7FC00000, 32'h0, 32'h00000200, 1'b0);
    issue(CLS, 3'b000, 32'h80000000, 32'h0, 32'h00000008, 1'b0);
    issue(CLS, 3'b000, 32'h00000000, 32'h0, 32'h00000010, 1'b0);
    issue(CLS, 3'b000, 32'h7F800000, 32'h0, 32'h00000080, 1'b0);
    issue(CLS, 3'b000, 32'hBF800000, 32'h0, 32'h00000002, 1'b0);
    issue(CLS, 3'b000, 32'h80000001, 32'h0, 32'h00000004, 1'b0);
    idle(2);

    issue(CMP, 3'b001, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1);
    issue(CMP, 3'b010, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b0);
    issue(CMP, 3'b000, 32'h80000000, 32'h00000000, 32'h1, 1'b0);
    issue(CMP, 3'b001, 32'h80000000, 32'h00000000, 32'h0, 1'b0);
    issue(CMP, 3'b010, 32'h80000000, 32'h00000000, 32'h1, 1'b0);
    issue(CMP, 3'b001, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0);
    issue(CMP, 3'b001, 32'hC0000000, 32'hBF800000, 32'h1, 1'b0);
    issue(CMP, 3'b000, 32'h3F800000, 32'hBF800000, 32'h0, 1'b0);
    issue(CMP, 3'b010, 32'h7F800001, 32'h7F800001, 32'h0, 1'b1);
    issue(CMP, 3'b000, 32'h7F800001, 32'h00000000, 32'h0, 1'b1);
    issue(CMP, 3'b011, 32'h3F800000, 32'h3F800000, 32'h0, 1'b0);
    issue(RSV, 3'b000, 32'h7F800001, 32'h3F800000, 32'h0, 1'b0);

`ifdef ECLIPTIC_MINMAX_EN
    issue(CMP, 3'b101, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
    issue(CMP, 3'b101, 32'h3F800000, 32'hCF800000, 32'h3F800000, 1'b0);
    issue(CMP, 3'b100, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    issue(CMP, 3'b101, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0);
    issue(CMP, 3'b100, 32'hBF800000, 32'hC0000000, 32'hC0000000, 1'b0);
    issue(CMP, 3'b100, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0);
`else
    issue(CMP, 3'b101, 32'h7F800001, 32'h3F800000, 32'h0, 1'b0);
    issue(CMP, 3'b101, 32'h3F800000, 32'hCF800000, 32'h0, 1'b0);
    issue(CMP, 3'b100, 32'h00000000, 32'h80000000, 32'h0, 1'b0);
    issue(CMP, 3'b101, 32'h7FC00000, 32'h7FC00000, 32'h0, 1'b0);
`endif
    drain();

    // Result must hold while req stays low
    idle(3);
    compared++;
    if (bus.res !== lastRes || bus.ack !== 1'b0) begin
      mismatched++;
      $display("FAIL hold got res=%h ack=%b want res=%h ack=0",
               bus.res, bus.ack, lastRes);
    end

    // Back-to-back stream of three
    issue(SGN, 3'b000, 32'h40000000, 32'h80000000, 32'hC0000000, 1'b0);
    issue(CLS, 3'b000, 32'hFF800000, 32'h0, 32'h00000001, 1'b0);
    issue(CMP, 3'b001, 32'h3F800000, 32'h40000000, 32'h1, 1'b0);
    drain();

    // Asynchronous reset mid-operation
    issue(SGN, 3'b011, 32'h12345678, 32'h0, 32'h12345678, 1'b0);
    bus.req = 1'b0;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checkZero("async_reset");
    expQ.delete();
    @(posedge clk);
    #1;
    checkZero("reset_held");
    nrst = 1'b1;
    idle(2);

    issue(CLS, 3'b000, 32'h00400000, 32'h0, 32'h00000020, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
